// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one clocked write port.
// Register 0 can be hardwired to zero through R0_ZERO.
module register_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rr1,
    output logic [DATA_W-1:0] rr2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wr,
    input  logic              wren
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              write_ok;
    logic              r0_hard;

    assign r0_hard = (R0_ZERO != 0);

    // A write to register 0 is dropped when it is hardwired to zero.
    always_comb begin
        write_ok = wren && !(r0_hard && (wa == '0));
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[wa] <= wr;
        end
    end

    // No bypass: reads see only committed state.
    assign rr1 = (r0_hard && (ra1 == '0)) ? '0 : regs[ra1];
    assign rr2 = (r0_hard && (ra2 == '0)) ? '0 : regs[ra2];

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against a simple array model.
module tb_register_file;

    logic        clk;
    logic        rstd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rr1;
    logic [31:0] rr2;
    logic [4:0]  wa;
    logic [31:0] wr;
    logic        wren;

    int checks;
    int failures;

    logic [31:0] model [32];

    register_file #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1)) dut (
        .clk  (clk),
        .rstd (rstd),
        .ra1  (ra1),
        .ra2  (ra2),
        .rr1  (rr1),
        .rr2  (rr2),
        .wa   (wa),
        .wr   (wr),
        .wren (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expected(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkRead(input logic [4:0] a1, input logic [4:0] a2);
        ra1 = a1;
        ra2 = a2;
        #1;
        checkOutput($sformatf("rr1[%0d]", a1), rr1, expected(a1));
        checkOutput($sformatf("rr2[%0d]", a2), rr2, expected(a2));
    endtask

    // One clock edge with the given controls; checks there is no bypass before the edge,
    // then applies the architectural rule to the model and returns controls to idle.
    task automatic applyStimulus(input logic rst_n, input logic wen,
                                 input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        rstd = rst_n;
        wren = wen;
        wa   = wen ? addr : 5'bx;
        wr   = wen ? data : 32'bx;
        ra1  = addr;
        ra2  = addr;
        #1;
        checkOutput("pre_edge_rr1", rr1, expected(addr));
        checkOutput("pre_edge_rr2", rr2, expected(addr));
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wen && addr != 5'd0) begin
            model[addr] = data;
        end
        #1;
        wren = 1'b0;
        rstd = 1'b1;
        checkRead(addr, addr);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstd = 1'b1;
        wren = 1'b0;
        wa   = '0;
        wr   = '0;
        ra1  = '0;
        ra2  = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset with no prior initialization, then sweep every address.
        @(negedge clk);
        rstd = 1'b0;
        @(posedge clk);
        #1;
        rstd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checkRead(5'(i), 5'(31 - i));
        end

        // Writes disabled: several idle edges must leave register 3 untouched.
        @(negedge clk);
        wa = 5'd3;
        wr = 32'hAAAAAAAA;
        wren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkRead(5'd3, 5'd3);

        applyStimulus(1'b1, 1'b1, 5'd8, 32'hAAAAAAAA);
        applyStimulus(1'b1, 1'b1, 5'd11, 32'hCCCCCCCC);
        applyStimulus(1'b1, 1'b1, 5'd11, 32'hDDDDDDDD);
        checkOutput("overwrite_r11", rr1, 32'hDDDDDDDD);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
        checkOutput("r0_zero", rr2, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h99999999);
        applyStimulus(1'b1, 1'b1, 5'd10, 32'h10101010);
        checkRead(5'd9, 5'd10);

        // Reset takes priority over a simultaneous write to register 9.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h11111111);
        checkOutput("reset_over_write_r9", rr1, 32'h0);
        for (int i = 8; i < 12; i++) checkRead(5'(i), 5'(i));

        // Random traffic: occasional resets, idle cycles with X controls, random reads.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 31)), $urandom);
            checkRead(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 32; i++) checkRead(5'(i), 5'(i ^ 5'h1f));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
